// File: rtl/flipflop_pingpong_ctrl_if.sv
// Ping-pong controller bus: producer write stream and
// consumer bank-select/ack handshake.
interface flipflop_pingpong_ctrl_if #(
  parameter int N = 16,
  parameter int M = 16
);
  localparam int IW = (M > 2) ? $clog2(M) : 1;

  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          wr_en0;
  logic          wr_en1;
  logic [IW-1:0] wr_idx;
  logic [N-1:0]  wr_data;
  logic          sel;
  logic          out_valid;
  logic          out_ack;
  logic [1:0]    full_cnt;

  modport master (
    output in_valid, in_data, out_ack,
    input  in_ready, wr_en0, wr_en1, wr_idx,
    input  wr_data, sel, out_valid, full_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ack,
    output in_ready, wr_en0, wr_en1, wr_idx,
    output wr_data, sel, out_valid, full_cnt
  );
endinterface

// File: rtl/flipflop_pingpong_ctrl.sv
// Ping-pong sequencer for two external M x N register banks:
// fills one bank while the consumer reads the other.
module flipflop_pingpong_ctrl #(
  parameter int N = 16,
  parameter int M = 16
) (
  input logic clk,
  input logic rst,
  input logic flush,
  flipflop_pingpong_ctrl_if.slave bus
);
  localparam int IW = (M > 2) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST = IW'(M - 1);

  logic          fill_ptr;
  logic [IW-1:0] cnt;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          sel_q;
  logic          last_q;
  logic          en0;
  logic          en1;
  logic [IW-1:0] idx;
  logic [N-1:0]  data;
  logic          wr_tgt;
  logic          ready;
  logic          accept;
  logic          rel;

  // bank targeted by the write currently on the bus
  assign wr_tgt = en1;

  assign ready  = !full[fill_ptr]
                  && !(last_q && (wr_tgt == fill_ptr));
  assign accept = bus.in_valid && ready;
  assign rel    = bus.out_ack && full[sel_q];

  always_comb begin
    full_nxt = full;
    if (rel)
      full_nxt[sel_q] = 1'b0;
    if (last_q)
      full_nxt[wr_tgt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_ptr <= 1'b0;
      cnt      <= '0;
      full     <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b0;
      en0      <= 1'b0;
      en1      <= 1'b0;
      idx      <= '0;
      data     <= '0;
    end else if (flush) begin
      fill_ptr <= 1'b0;
      cnt      <= '0;
      full     <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b0;
      en0      <= 1'b0;
      en1      <= 1'b0;
      idx      <= '0;
      data     <= '0;
    end else begin
      full   <= full_nxt;
      last_q <= 1'b0;
      en0    <= 1'b0;
      en1    <= 1'b0;
      if (rel)
        sel_q <= ~sel_q;
      if (accept) begin
        en0  <= ~fill_ptr;
        en1  <= fill_ptr;
        idx  <= cnt;
        data <= bus.in_data;
        if (cnt == LAST) begin
          last_q   <= 1'b1;
          cnt      <= '0;
          fill_ptr <= ~fill_ptr;
        end else begin
          cnt <= cnt + IW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.wr_en0    = en0;
  assign bus.wr_en1    = en1;
  assign bus.wr_idx    = idx;
  assign bus.wr_data   = data;
  assign bus.sel       = sel_q;
  assign bus.out_valid = full[sel_q];
  assign bus.full_cnt  = 2'(full[0]) + 2'(full[1]);
endmodule
